fp_accumulate: RTL and testbench
================================

Name: fp_accumulate

Overview:
Sequential reduction stage that feeds fp_add and registers its output. It takes a stream of fp_t (1 sign, 8 exponent, 7 mantissa) terms over a valid/ready handshake and sums a programmed number of them into an internal accumulator. One fp_add instance is combinational inside the loop. The result goes downstream over a valid/ready output, which gives neuron/dot-product datapaths a single-port sum engine.

Parameters:
CNT_W, 8, width of term count; max terms per job = 2**CNT_W - 1

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  begin a job; sampled only in IDLE
num_terms_i  input  CNT_W  terms in job; sampled with start_i
in_valid_i  input  1  input term valid
in_ready_o  output  1  block accepts term
in_data_i  input  16 (fp_t)  input term
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts result
out_data_o  output  16 (fp_t)  accumulated sum
busy_o  output  1  high in any state other than IDLE

Behaviour:
- One clock (clk_i). Reset is asynchronous, active-low (rst_ni). All state is asserted on negedge rst_ni and released synchronously.
- Reset values:
  - state = IDLE
  - acc = 16'h0000
  - count = 0
  - first flag = 1
  - in_ready_o = 0, out_valid_o = 0, busy_o = 0
  - out_data_o = 16'h0000
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - start_i=1 and num_terms_i>0: count <= num_terms_i, first <= 1, acc <= 16'h0000, next state ACCUM.
  - start_i=1 and num_terms_i==0: acc <= 16'h0000, next state OUTPUT.
  - start_i=0: stay in IDLE.
- ACCUM:
  - in_ready_o = 1 (combinational from state only, no dependence on in_valid_i).
  - A term is accepted on any cycle with in_valid_i && in_ready_o.
  - First accepted term: acc <= in_data_i directly, bypassing fp_add. This removes any dependence on fp_add zero handling. first <= 0.
  - Later accepted terms: acc <= fp_add(acc, in_data_i). The result is registered, so throughput is 1 term/cycle.
  - count decrements on each accept. An accept with count==1 moves to OUTPUT.
  - in_valid_i low: hold all state.
- OUTPUT:
  - out_valid_o = 1, out_data_o = acc, in_ready_o = 0.
  - Result valid the cycle after the last accepted term (latency 1).
  - out_valid_o and out_data_o stay stable until out_ready_i=1. The handshake returns to IDLE.
- start_i is ignored in ACCUM and OUTPUT. No queueing.
- A new job can start in the cycle after the output handshake. Minimum job-to-job gap is 1 IDLE cycle.
- Arithmetic: fp_add rounding and special-value behaviour are inherited unchanged. No extra normalisation or saturation.
- out_data_o is driven from acc in all states, but is meaningful only while out_valid_o=1.
- Reset asserted mid-ACCUM or mid-OUTPUT: job is aborted immediately, all reset values apply, no output handshake occurs.

Optional Feature:
FP_ACC_BIAS_EN
- Defined:
  - Adds port bias_i (input, 16, fp_t), sampled with start_i.
  - start_i loads acc <= bias_i and first <= 0, so every term, including the first, goes through fp_add.
  - num_terms_i==0 outputs bias_i.
- Undefined:
  - Port absent.
  - Behaviour exactly as above: first term loaded directly; an empty job outputs 16'h0000.

Test Plan:
- Start num_terms_i=3; terms 0x3F80, 0x3F80, 0x3F80 on consecutive cycles; out_ready_i=1 -> out_data_o=0x4040 (3.0), out_valid_o high 1 cycle after the third accept, then IDLE.
- num_terms_i=2; terms 0x3F80 (1.0) then 0xBF00 (-0.5), with in_valid_i low 3 cycles between them -> count held, in_ready_o stays 1, result 0x3F00 (0.5).
- num_terms_i=1, term 0x4000 -> 0x4000 unchanged. Then num_terms_i=0 -> out_valid_o next cycle with 0x0000.
- Backpressure: 2 terms 0x3FC0 + 0x3FC0, out_ready_i low 5 cycles -> out_valid_o=1 and out_data_o=0x4040 held 5 cycles, in_ready_o=0, start_i pulses ignored. Handshake completes on the 6th cycle.
- Reset mid-job: num_terms_i=4, assert rst_ni low after 2 accepts -> immediately busy_o=0, out_valid_o=0, state IDLE. A fresh 1-term job of 0x3F80 returns 0x3F80.
- FP_ACC_BIAS_EN build:
  - bias_i=0x3F80, num_terms_i=2, terms 0x3F80, 0x3F80 -> 0x4040.
  - bias_i=0x4000, num_terms_i=0 -> 0x4000.

Source files
------------

// File: rtl/fp_accumulate_if.sv
// Handshake bundle for fp_accumulate: job start, term stream in, sum out.
// With FP_ACC_BIAS_EN defined the bundle also carries the per-job bias term.
interface fp_accumulate_if #(
    parameter int CNT_W = 8
);
    logic             start_i;
    logic [CNT_W-1:0] num_terms_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [15:0]      in_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [15:0]      out_data_o;
    logic             busy_o;
`ifdef FP_ACC_BIAS_EN
    logic [15:0]      bias_i;
`endif

    modport master (
`ifdef FP_ACC_BIAS_EN
        output bias_i,
`endif
        output start_i, num_terms_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, busy_o
    );

    modport slave (
`ifdef FP_ACC_BIAS_EN
        input  bias_i,
`endif
        input  start_i, num_terms_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, busy_o
    );
endinterface

// File: rtl/fp_accumulate.sv
// Single-port bfloat16 sum engine: accumulates a programmed number of terms through one fp_add.
// Optional FP_ACC_BIAS_EN: start loads a bias into the accumulator and every term goes through fp_add.
module fp_accumulate #(
    parameter int CNT_W = 8
) (
    input logic           clk_i,
    input logic           rst_ni,
    fp_accumulate_if.slave bus
);
    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } fp_t;

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    // Round-to-nearest-even add; subnormal inputs flush to zero, any NaN or inf-inf gives 0x7FC0.
    function automatic fp_t fp_add(input fp_t a_in, input fp_t b_in);
        fp_t         a, b, t, r;
        logic [11:0] ma, mb, sum;
        logic [8:0]  rnd;
        logic [7:0]  d;
        logic        sticky;
        int          e, hi;
        a = a_in;
        b = b_in;
        r = '0;
        if (a.exp == 8'd0) a.man = '0;
        if (b.exp == 8'd0) b.man = '0;
        if (a.exp == 8'hFF || b.exp == 8'hFF) begin
            if ((a.exp == 8'hFF && a.man != '0) || (b.exp == 8'hFF && b.man != '0) ||
                (a.exp == 8'hFF && b.exp == 8'hFF && a.sign != b.sign))
                r = 16'h7FC0;
            else
                r = (a.exp == 8'hFF) ? a : b;
        end else if (a.exp == 8'd0 && b.exp == 8'd0) begin
            r = {a.sign & b.sign, 15'd0};
        end else if (a.exp == 8'd0) begin
            r = b;
        end else if (b.exp == 8'd0) begin
            r = a;
        end else begin
            if ({b.exp, b.man} > {a.exp, a.man}) begin
                t = a;
                a = b;
                b = t;
            end
            d  = a.exp - b.exp;
            ma = {2'b01, a.man, 3'b000};
            mb = {2'b01, b.man, 3'b000};
            // Guard/round/sticky in the low three bits keep the rounding exact for subtraction too.
            if (d > 8'd11) begin
                sticky = 1'b1;
                mb     = '0;
            end else begin
                sticky = |(mb & ((12'd1 << d) - 12'd1));
                mb     = mb >> d;
            end
            mb[0] = mb[0] | sticky;
            sum   = (a.sign == b.sign) ? ma + mb : ma - mb;
            e     = int'(a.exp);
            if (sum != '0) begin
                if (sum[11]) begin
                    sum = {1'b0, sum[11:2], sum[1] | sum[0]};
                    e   = e + 1;
                end else begin
                    hi = 0;
                    for (int i = 0; i <= 10; i++)
                        if (sum[i]) hi = i;
                    sum = sum << (10 - hi);
                    e   = e - (10 - hi);
                end
                rnd = {1'b0, sum[10:3]} + 9'(sum[2] & (sum[3] | sum[1] | sum[0]));
                if (rnd[8]) begin
                    rnd = rnd >> 1;
                    e   = e + 1;
                end
                if (e >= 255)
                    r = {a.sign, 8'hFF, 7'd0};
                else if (e <= 0)
                    r = {a.sign, 15'd0};
                else
                    r = {a.sign, e[7:0], rnd[6:0]};
            end
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    fp_t              acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             first_q, first_d;
    logic             accept;

    assign bus.in_ready_o  = (state_q == ACCUM);
    assign bus.out_valid_o = (state_q == OUTPUT);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.out_data_o  = acc_q;
    assign accept          = bus.in_valid_i && (state_q == ACCUM);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        first_d = first_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
`ifdef FP_ACC_BIAS_EN
                    acc_d = bus.bias_i;
`else
                    acc_d = '0;
`endif
                    if (bus.num_terms_i == '0) begin
                        state_d = OUTPUT;
                    end else begin
                        count_d = bus.num_terms_i;
`ifdef FP_ACC_BIAS_EN
                        first_d = 1'b0;
`else
                        first_d = 1'b1;
`endif
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = first_q ? fp_t'(bus.in_data_i) : fp_add(acc_q, bus.in_data_i);
                    first_d = 1'b0;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            first_q <= first_d;
        end
    end
endmodule

// File: tb/tb_fp_accumulate.sv
// Self-checking bench for fp_accumulate: directed jobs plus random jobs scored against a real-arithmetic model.
// Build with FP_ACC_BIAS_EN defined to exercise the bias variant.
module tb_fp_accumulate;
    localparam int CNT_W = 8;
`ifdef FP_ACC_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] bias_v;
    logic [15:0] q[$];

    fp_accumulate_if #(.CNT_W(CNT_W)) bus ();
    fp_accumulate #(.CNT_W(CNT_W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp_v);
        end
    endtask

    function automatic real to_real(input logic [15:0] v);
        logic [63:0] b;
        if (v[14:7] == 8'd0) return 0.0;
        b = {v[15], 11'(int'(v[14:7]) - 127 + 1023), v[6:0], 45'd0};
        return $bitstoreal(b);
    endfunction

    // Round a real to the nearest bfloat16, ties to even.
    function automatic logic [15:0] to_bf16(input real r);
        logic [63:0] b;
        logic [44:0] rem;
        logic [7:0]  m;
        int          e;
        if (r == 0.0) return 16'h0000;
        b   = $realtobits(r);
        e   = int'(b[62:52]) - 1023 + 127;
        m   = {1'b0, b[51:45]};
        rem = b[44:0];
        if (rem > 45'h1000_0000_0000 || (rem == 45'h1000_0000_0000 && m[0])) m = m + 8'd1;
        if (m[7]) begin
            m = 8'd0;
            e = e + 1;
        end
        return {b[63], e[7:0], m[6:0]};
    endfunction

    function automatic logic [15:0] model_job(input logic [15:0] bias, input logic [15:0] terms[$]);
        logic [15:0] acc;
        int          first_add;
        if (BIAS_EN) begin
            acc       = bias;
            first_add = 0;
        end else begin
            if (terms.size() == 0) return 16'h0000;
            acc       = terms[0];
            first_add = 1;
        end
        for (int i = first_add; i < terms.size(); i++)
            acc = to_bf16(to_real(acc) + to_real(terms[i]));
        return acc;
    endfunction

    function automatic logic [15:0] rand_term();
        return {1'($urandom), 8'($urandom_range(134, 120)), 7'($urandom)};
    endfunction

    // Called on a falling edge; returns on the falling edge after the output handshake.
    task automatic run_job(input string tag, input logic [15:0] terms[$], input int gap_lo,
                           input int gap_hi, input int hold, input logic [15:0] exp_v);
        bus.out_ready_i = (hold == 0);
`ifdef FP_ACC_BIAS_EN
        bus.bias_i = bias_v;
`endif
        bus.start_i     = 1'b1;
        bus.num_terms_i = CNT_W'(terms.size());
        @(negedge clk);
        bus.start_i = 1'b0;
        check({tag, "/busy"}, 16'(bus.busy_o), 16'd1);
        foreach (terms[i]) begin
            if (i > 0) begin
                repeat ($urandom_range(gap_hi, gap_lo)) begin
                    check({tag, "/gap_ready"}, 16'(bus.in_ready_o), 16'd1);
                    check({tag, "/gap_valid"}, 16'(bus.out_valid_o), 16'd0);
                    bus.start_i     = 1'($urandom);
                    bus.num_terms_i = CNT_W'(1);
                    @(negedge clk);
                    bus.start_i = 1'b0;
                end
            end
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = terms[i];
            check({tag, "/in_ready"}, 16'(bus.in_ready_o), 16'd1);
            @(negedge clk);
            bus.in_valid_i = 1'b0;
            bus.in_data_i  = 16'($urandom);
        end
        check({tag, "/out_valid"}, 16'(bus.out_valid_o), 16'd1);
        check({tag, "/out_data"}, bus.out_data_o, exp_v);
        check({tag, "/out_in_ready"}, 16'(bus.in_ready_o), 16'd0);
        repeat (hold) begin
            bus.start_i     = 1'b1;
            bus.num_terms_i = CNT_W'(1);
            @(negedge clk);
            check({tag, "/hold_valid"}, 16'(bus.out_valid_o), 16'd1);
            check({tag, "/hold_data"}, bus.out_data_o, exp_v);
            check({tag, "/hold_in_ready"}, 16'(bus.in_ready_o), 16'd0);
        end
        bus.start_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check({tag, "/idle_busy"}, 16'(bus.busy_o), 16'd0);
        check({tag, "/idle_valid"}, 16'(bus.out_valid_o), 16'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bias_v          = 16'h0000;
        bus.start_i     = 1'b0;
        bus.num_terms_i = '0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 16'h0000;
        bus.out_ready_i = 1'b1;
`ifdef FP_ACC_BIAS_EN
        bus.bias_i = 16'h0000;
`endif
        repeat (2) @(negedge clk);
        check("rst/busy", 16'(bus.busy_o), 16'd0);
        check("rst/in_ready", 16'(bus.in_ready_o), 16'd0);
        check("rst/out_valid", 16'(bus.out_valid_o), 16'd0);
        check("rst/out_data", bus.out_data_o, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        q = {16'h3F80, 16'h3F80, 16'h3F80};
        run_job("three_ones", q, 0, 0, 0, 16'h4040);
        q = {16'h3F80, 16'hBF00};
        run_job("gap3", q, 3, 3, 0, 16'h3F00);
        q = {16'h4000};
        run_job("single", q, 0, 0, 0, 16'h4000);
        q.delete();
        run_job("empty", q, 0, 0, 0, 16'h0000);
        q = {16'h3FC0, 16'h3FC0};
        run_job("backpressure", q, 0, 0, 5, 16'h4040);

        bus.start_i     = 1'b1;
        bus.num_terms_i = CNT_W'(4);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 16'h3F80;
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort/busy", 16'(bus.busy_o), 16'd0);
        check("abort/out_valid", 16'(bus.out_valid_o), 16'd0);
        check("abort/in_ready", 16'(bus.in_ready_o), 16'd0);
        check("abort/out_data", bus.out_data_o, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q = {16'h3F80};
        run_job("after_abort", q, 0, 0, 0, 16'h3F80);

`ifdef FP_ACC_BIAS_EN
        bias_v = 16'h3F80;
        q = {16'h3F80, 16'h3F80};
        run_job("bias_two", q, 0, 0, 0, 16'h4040);
        bias_v = 16'h4000;
        q.delete();
        run_job("bias_empty", q, 0, 0, 0, 16'h4000);
`endif

        for (int j = 0; j < 24; j++) begin
            int n;
            n = (j % 8 == 7) ? 0 : int'($urandom_range(12, 1));
            if (j == 10) n = 255;
            bias_v = BIAS_EN ? rand_term() : 16'h0000;
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(rand_term());
            run_job($sformatf("rand%0d", j), q, 0, (n == 255) ? 0 : 2,
                    int'($urandom_range(3, 0)), model_job(bias_v, q));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
